// File: rtl/dds_sweep_ctrl.sv
// Sweep sequencer for the DDS phase accumulator: steps the tuning word from
// k_start to k_stop on sample ticks, or passes the manual switches through when idle.
module dds_sweep_ctrl #(
   parameter int unsigned K_W     = 8,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic               start,
   input  logic               stop,
   input  logic [1:0]         mode,
   input  logic [K_W-1:0]     k_start,
   input  logic [K_W-1:0]     k_stop,
   input  logic [K_W-1:0]     k_step,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [K_W-1:0]     manual_k,
   input  logic [3:0]         wave_sel_in,
   output logic [K_W-1:0]     k_out,
   output logic [3:0]         wave_sel,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               dir
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_DWELL,
      S_DONE
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [K_W-1:0]     r_k_out;
   logic [3:0]         r_wave_sel;
   logic               r_dir;
   logic               r_err;
   logic [DWELL_W-1:0] r_dwell_cnt;

   logic [1:0]         r_mode;
   logic [K_W-1:0]     r_k_start;
   logic [K_W-1:0]     r_k_stop;
   logic [K_W-1:0]     r_k_step;
   logic [DWELL_W-1:0] r_dwell;

   logic [K_W-1:0]     w_k_nxt;
   logic [3:0]         w_wave_nxt;
   logic               w_dir_nxt;
   logic               w_err_nxt;
   logic [DWELL_W-1:0] w_cnt_nxt;
   logic               w_latch;

   logic               w_cfg_bad;
   logic [K_W:0]       w_up;
   logic [K_W:0]       w_dn;
   logic               w_up_ok;
   logic               w_dn_ok;

   // One extra bit on both candidates so overflow/borrow never wraps into k_out.
   assign w_cfg_bad = (k_step == '0) || (k_start > k_stop);
   assign w_up      = {1'b0, r_k_out} + {1'b0, r_k_step};
   assign w_dn      = {1'b0, r_k_out} - {1'b0, r_k_step};
   assign w_up_ok   = (w_up <= {1'b0, r_k_stop});
   assign w_dn_ok   = !w_dn[K_W] && (w_dn[K_W-1:0] >= r_k_start);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_k_nxt     = r_k_out;
      w_wave_nxt  = r_wave_sel;
      w_dir_nxt   = r_dir;
      w_err_nxt   = 1'b0;
      w_cnt_nxt   = r_dwell_cnt;
      w_latch     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_k_nxt    = manual_k;
            w_wave_nxt = wave_sel_in;
            if (start && !stop) begin
               if (w_cfg_bad) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_latch     = 1'b1;
                  w_dir_nxt   = 1'b0;
                  w_state_nxt = S_ARM;
               end
            end
         end

         S_ARM: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (tick) begin
               w_k_nxt     = r_k_start;
               w_cnt_nxt   = r_dwell;
               w_state_nxt = S_DWELL;
            end
         end

         S_DWELL: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end else if (tick) begin
               if (r_dwell_cnt != '0) begin
                  w_cnt_nxt = r_dwell_cnt - DWELL_W'(1);
               end else begin
                  w_cnt_nxt = r_dwell;
                  if (!r_dir) begin
                     if (w_up_ok) begin
                        w_k_nxt = w_up[K_W-1:0];
                     end else begin
                        case (r_mode)
                           2'b01: w_k_nxt = r_k_start;
                           2'b10: begin
                              w_dir_nxt = 1'b1;
                              if (w_dn_ok) w_k_nxt = w_dn[K_W-1:0];
                           end
                           default: w_state_nxt = S_DONE;
                        endcase
                     end
                  end else begin
                     if (w_dn_ok) begin
                        w_k_nxt = w_dn[K_W-1:0];
                     end else begin
                        w_dir_nxt = 1'b0;
                        if (w_up_ok) w_k_nxt = w_up[K_W-1:0];
                     end
                  end
               end
            end
         end

         S_DONE: begin
            w_k_nxt     = manual_k;
            w_wave_nxt  = wave_sel_in;
            w_state_nxt = S_IDLE;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_k_out     <= '0;
         r_wave_sel  <= '0;
         r_dir       <= 1'b0;
         r_err       <= 1'b0;
         r_dwell_cnt <= '0;
         r_mode      <= '0;
         r_k_start   <= '0;
         r_k_stop    <= '0;
         r_k_step    <= '0;
         r_dwell     <= '0;
      end else begin
         r_k_out     <= w_k_nxt;
         r_wave_sel  <= w_wave_nxt;
         r_dir       <= w_dir_nxt;
         r_err       <= w_err_nxt;
         r_dwell_cnt <= w_cnt_nxt;
         if (w_latch) begin
            r_mode    <= mode;
            r_k_start <= k_start;
            r_k_stop  <= k_stop;
            r_k_step  <= k_step;
            r_dwell   <= dwell;
         end
      end
   end

   assign k_out    = r_k_out;
   assign wave_sel = r_wave_sel;
   assign busy     = (r_state == S_ARM) || (r_state == S_DWELL);
   assign done     = (r_state == S_DONE);
   assign err      = r_err;
   assign dir      = r_dir;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: manual pass-through, single/ping-pong/repeat
// sweeps, stop/reset aborts and rejected starts against hand-computed sequences.
module tb_dds_sweep_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        start;
   logic        stop;
   logic [1:0]  mode;
   logic [7:0]  k_start;
   logic [7:0]  k_stop;
   logic [7:0]  k_step;
   logic [15:0] dwell;
   logic [7:0]  manual_k;
   logic [3:0]  wave_sel_in;
   logic [7:0]  k_out;
   logic [3:0]  wave_sel;
   logic        busy;
   logic        done;
   logic        err;
   logic        dir;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   logic [7:0] exp_single [8] = '{8'd10, 8'd20, 8'd20, 8'd30, 8'd30, 8'd40, 8'd40, 8'd40};
   logic [7:0] exp_pp_k   [5] = '{8'd254, 8'd250, 8'd254, 8'd250, 8'd254};
   logic       exp_pp_dir [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [7:0] exp_rep    [8] = '{8'd3, 8'd6, 8'd9, 8'd0, 8'd3, 8'd6, 8'd9, 8'd0};

   always #5 clk = ~clk;

   dds_sweep_ctrl #(.K_W(8), .DWELL_W(16)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .start       (start),
      .stop        (stop),
      .mode        (mode),
      .k_start     (k_start),
      .k_stop      (k_stop),
      .k_step      (k_step),
      .dwell       (dwell),
      .manual_k    (manual_k),
      .wave_sel_in (wave_sel_in),
      .k_out       (k_out),
      .wave_sel    (wave_sel),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .dir         (dir)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
      k_start = '0; k_stop = '0; k_step = '0; dwell = '0;
      manual_k = 8'h00; wave_sel_in = 4'h0;
      repeat (3) step();
      chk("rst_k", k_out, 0);
      chk("rst_wave", wave_sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_dir", dir, 0);

      rst = 1'b0; manual_k = 8'h20; wave_sel_in = 4'd3;
      step();
      chk("man_k", k_out, 8'h20);
      chk("man_wave", wave_sel, 3);
      chk("man_busy", busy, 0);

      // single-up sweep, dwell 1
      mode = 2'b00; k_start = 8'd10; k_stop = 8'd40; k_step = 8'd10; dwell = 16'd1;
      wave_sel_in = 4'd5;
      pulse_start();
      chk("sgl_arm_busy", busy, 1);
      chk("sgl_arm_wave", wave_sel, 5);
      step();
      chk("sgl_arm_hold", k_out, 8'h20);
      do_tick();
      chk("sgl_first", k_out, 10);
      for (int i = 0; i < 8; i++) begin
         do_tick();
         chk("sgl_k", k_out, exp_single[i]);
         chk("sgl_done", done, (i == 7));
         chk("sgl_busy", busy, (i != 7));
         if (i == 0) begin
            step(); step();
            chk("sgl_gap_hold", k_out, 10);
         end
         if (i == 2) begin
            k_step = 8'd1; k_stop = 8'd200; wave_sel_in = 4'd7;
            pulse_start();
            chk("sgl_restart_ign", k_out, 20);
            chk("sgl_wave_latched", wave_sel, 5);
         end
      end
      step();
      chk("sgl_done_1clk", done, 0);
      step();
      chk("sgl_back_manual", k_out, 8'h20);
      chk("sgl_back_wave", wave_sel, 7);

      // ping-pong near the top of the range
      mode = 2'b10; k_start = 8'd250; k_stop = 8'd255; k_step = 8'd4; dwell = 16'd0;
      pulse_start();
      do_tick();
      chk("pp_first", k_out, 250);
      chk("pp_first_dir", dir, 0);
      for (int i = 0; i < 5; i++) begin
         do_tick();
         chk("pp_k", k_out, exp_pp_k[i]);
         chk("pp_dir", dir, exp_pp_dir[i]);
      end
      stop = 1'b1; tick = 1'b1;
      step();
      stop = 1'b0; tick = 1'b0;
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      chk("stop_k_hold", k_out, 254);
      step();
      chk("stop_done2", done, 0);
      step();
      chk("stop_manual", k_out, 8'h20);

      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk("ss_busy", busy, 0);
      step();
      chk("ss_busy2", busy, 0);
      chk("ss_err", err, 0);

      // repeat sawtooth, then reset mid-sweep
      mode = 2'b01; k_start = 8'd0; k_stop = 8'd9; k_step = 8'd3; dwell = 16'd0;
      pulse_start();
      do_tick();
      chk("rep_first", k_out, 0);
      for (int i = 0; i < 8; i++) begin
         do_tick();
         chk("rep_k", k_out, exp_rep[i]);
         chk("rep_done", done, 0);
      end
      do_tick();
      chk("rep_k_pre_rst", k_out, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_k", k_out, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dir", dir, 0);

      // rejected starts
      k_step = 8'd0; k_start = 8'd0; k_stop = 8'd9;
      pulse_start();
      chk("err_step0", err, 1);
      chk("err_step0_busy", busy, 0);
      step();
      chk("err_step0_pulse", err, 0);
      chk("err_step0_busy2", busy, 0);
      k_step = 8'd1; k_start = 8'd50; k_stop = 8'd20;
      pulse_start();
      chk("err_order", err, 1);
      chk("err_order_busy", busy, 0);
      step();
      chk("err_order_pulse", err, 0);
      chk("err_order_busy2", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sweep sequencer that configures the DDS phase accumulator at run time. It drives the 8-bit tuning word and the waveform select, and steps the tuning word from a start value to a stop value. Each point is held for a programmable number of sample ticks. Tuning-word updates are aligned to the 10 kHz sample strobe, so the accumulator never sees a mid-sample change. When idle, the block passes the manual switch settings through.

Parameters:
K_W, 8, tuning word / address increment width
DWELL_W, 16, dwell counter width (ticks per point minus one)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-clk-wide pulse per DDS sample (10 kHz strobe in clk domain)
start  in  1  one-clk pulse; begin sweep
stop  in  1  one-clk pulse; abort sweep
mode  in  2  00 single-up, 01 repeat (sawtooth), 10 ping-pong, 11 = single-up
k_start  in  K_W  first tuning word
k_stop  in  K_W  upper bound tuning word
k_step  in  K_W  increment per point
dwell  in  DWELL_W  point held for dwell+1 ticks
manual_k  in  K_W  switch tuning word used when idle
wave_sel_in  in  4  switch waveform select
k_out  out  K_W  tuning word to accumulator
wave_sel  out  4  waveform select to ROM mux
busy  out  1  high in ARM/DWELL
done  out  1  one-clk pulse at single-mode completion
err  out  1  one-clk pulse on rejected start
dir  out  1  0 = ascending, 1 = descending (ping-pong only)

Behaviour:
- Reset: state IDLE. k_out=0, wave_sel=0, busy=0, done=0, err=0, dir=0, dwell_cnt=0, latched config=0.
- IDLE: k_out<=manual_k and wave_sel<=wave_sel_in every clk (1-clk latency).
- IDLE start handling:
  - start with k_step==0 or k_start>k_stop: err pulse, stay IDLE.
  - valid start: latch mode/k_start/k_stop/k_step/dwell/wave_sel_in, dir<=0, go ARM.
- ARM: busy=1. k_out and wave_sel hold the latched values. On tick: k_out<=k_start, dwell_cnt<=dwell, go DWELL.
- DWELL, on each tick:
  - if dwell_cnt!=0: dwell_cnt--.
  - else compute the next point and reload dwell_cnt<=dwell.
  - k_out changes only in the clk after a tick.
- Next point, ascending: nxt = {1'b0,k_out}+k_step (K_W+1 bits). If nxt<=k_stop: k_out<=nxt. Otherwise endpoint:
  - single: go DONE; k_out holds the last point.
  - repeat: k_out<=k_start.
  - ping-pong: dir<=1; k_out<=k_out-k_step if that is >=k_start with no borrow, else k_out holds.
- Next point, descending (ping-pong only): nxt = k_out-k_step with borrow. If there is no borrow and nxt>=k_start: k_out<=nxt. Otherwise: dir<=0; k_out<=k_out+k_step if <=k_stop, else k_out holds.
- DONE: one clk; done=1, busy=0; then IDLE. k_out reverts to manual_k one clk later.
- stop in ARM/DWELL: IDLE next clk, busy=0, no done pulse.
- Priority and ignored inputs:
  - stop beats tick and start in the same cycle.
  - start while busy is ignored.
  - Config inputs changing during a sweep are ignored.
- Arithmetic: all compares are unsigned, with no wrap past 2^K_W-1.
- Reset mid-sweep returns to reset values on the next clk.

Test Plan:
- Reset, then manual_k=0x20, wave_sel_in=3 → k_out=0x20, wave_sel=3 one clk after the inputs are set. busy=0.
- Single mode, k_start=10, k_stop=40, step=10, dwell=1, start → k_out sequence 10,20,30,40, each held 2 ticks. Done pulse on the clk after the 8th tick following the ARM tick. Then k_out=manual_k.
- Ping-pong, k_start=250, k_stop=255, step=4, dwell=0 → 250,254,250,254… with no 9-bit overflow into k_out. dir toggles 0/1 at each turn.
- Repeat mode, k_start=0, k_stop=9, step=3, dwell=0 → 0,3,6,9,0,3… and done never asserts.
- Stop asserted in the same clk as a tick mid-sweep → IDLE, busy=0 next clk, no done. Start+stop together in IDLE → stays IDLE.
- Start with k_step=0, and start with k_start=50, k_stop=20 → err pulse 1 clk each, busy stays 0. Start pulsed while busy → no effect on the sequence.
